// File: rtl/bpd_upd_pkg.sv
// Shared constants for the branch-predictor update arbiter.
// Source encodings and payload flag bit positions.
package bpd_upd_pkg;
  localparam logic [1:0] SRC_MIS = 2'd0;
  localparam logic [1:0] SRC_REP = 2'd1;
  localparam logic [1:0] SRC_CMT = 2'd2;

  localparam int FLAG_MIS_BIT  = 0;
  localparam int FLAG_REP_BIT  = 1;
  localparam int UPD_W_DEFAULT = 412;
endpackage

// File: rtl/bpd_upd_prio_sel.sv
// Fixed-priority 3-way select (mis > rep > cmt) with forced-cmt override.
// Grants are one-hot, indexed by source encoding.
module bpd_upd_prio_sel
  import bpd_upd_pkg::*;
(
  input  logic       mis_valid,
  input  logic       rep_valid,
  input  logic       cmt_valid,
  input  logic       force_cmt,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    if (force_cmt && cmt_valid) begin
      gnt[SRC_CMT] = 1'b1;
    end else if (mis_valid) begin
      gnt[SRC_MIS] = 1'b1;
    end else if (rep_valid) begin
      gnt[SRC_REP] = 1'b1;
    end else if (cmt_valid) begin
      gnt[SRC_CMT] = 1'b1;
    end
  end

endmodule

// File: rtl/bpd_update_arbiter.sv
// Arbitrates mispredict, repair and commit updates onto the single
// predictor update port through a 1-entry registered output stage.
module bpd_update_arbiter
  import bpd_upd_pkg::*;
#(
  parameter int UPD_W        = UPD_W_DEFAULT,
  parameter int STARVE_LIMIT = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             mis_valid,
  output logic             mis_ready,
  input  logic [UPD_W-1:0] mis_bits,
  input  logic             rep_valid,
  output logic             rep_ready,
  input  logic [UPD_W-1:0] rep_bits,
  input  logic             cmt_valid,
  output logic             cmt_ready,
  input  logic [UPD_W-1:0] cmt_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UPD_W-1:0] out_bits,
  output logic [1:0]       out_src,
  output logic [7:0]       starve_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic             out_valid_q, out_valid_d;
  logic [UPD_W-1:0] out_bits_q, out_bits_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [7:0]       starve_q, starve_d;

  logic       can_load;
  logic       force_cmt;
  logic       open_q;
  logic [2:0] gnt;

  assign can_load  = ~out_valid_q | out_ready;
  assign force_cmt = (starve_q == LIMIT);
  assign open_q    = can_load & ~flush & ~reset;

  bpd_upd_prio_sel u_sel (
    .mis_valid (mis_valid),
    .rep_valid (rep_valid),
    .cmt_valid (cmt_valid),
    .force_cmt (force_cmt),
    .gnt       (gnt)
  );

  assign mis_ready = open_q & gnt[SRC_MIS];
  assign rep_ready = open_q & gnt[SRC_REP];
  assign cmt_ready = open_q & gnt[SRC_CMT];

  always_comb begin
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    out_src_d   = out_src_q;
    starve_d    = starve_q;
    if (flush) begin
      out_valid_d = 1'b0;
      starve_d    = 8'd0;
    end else begin
      if (mis_ready) begin
        out_valid_d = 1'b1;
        out_src_d   = SRC_MIS;
        out_bits_d  = mis_bits;
        out_bits_d[FLAG_MIS_BIT] = 1'b1;
        out_bits_d[FLAG_REP_BIT] = 1'b0;
      end else if (rep_ready) begin
        out_valid_d = 1'b1;
        out_src_d   = SRC_REP;
        out_bits_d  = rep_bits;
        out_bits_d[FLAG_MIS_BIT] = 1'b0;
        out_bits_d[FLAG_REP_BIT] = 1'b1;
      end else if (cmt_ready) begin
        out_valid_d = 1'b1;
        out_src_d   = SRC_CMT;
        out_bits_d  = cmt_bits;
        out_bits_d[FLAG_MIS_BIT] = 1'b0;
        out_bits_d[FLAG_REP_BIT] = 1'b0;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      // Starvation only advances in cycles where a grant could be taken.
      if (can_load) begin
        if (gnt[SRC_CMT]) begin
          starve_d = 8'd0;
        end else if (cmt_valid && starve_q != LIMIT) begin
          starve_d = starve_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_src_q   <= SRC_MIS;
      starve_q    <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_src_q   <= out_src_d;
      starve_q    <= starve_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bits   = out_bits_q;
  assign out_src    = out_src_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_bpd_update_arbiter.sv
// Directed bench for bpd_update_arbiter: priority, starvation,
// backpressure, flush and reset behaviour.
module tb_bpd_update_arbiter;
  localparam int W = 412;

  logic         clock = 1'b0;
  logic         reset, flush, out_ready;
  logic         mis_valid, rep_valid, cmt_valid;
  logic         mis_ready, rep_ready, cmt_ready;
  logic [W-1:0] mis_bits, rep_bits, cmt_bits, out_bits;
  logic         out_valid;
  logic [1:0]   out_src;
  logic [7:0]   starve_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bpd_update_arbiter #(.UPD_W(W), .STARVE_LIMIT(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .mis_valid  (mis_valid),
    .mis_ready  (mis_ready),
    .mis_bits   (mis_bits),
    .rep_valid  (rep_valid),
    .rep_ready  (rep_ready),
    .rep_bits   (rep_bits),
    .cmt_valid  (cmt_valid),
    .cmt_ready  (cmt_ready),
    .cmt_bits   (cmt_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_src    (out_src),
    .starve_cnt (starve_cnt)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fl(input logic [W-1:0] b,
                                      input logic [1:0] f);
    logic [W-1:0] r;
    r = b;
    r[1:0] = f;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rdy(input string tag, input logic m, input logic r,
                     input logic c);
    #1;
    chk({tag, "_mis_rdy"}, W'(mis_ready), W'(m));
    chk({tag, "_rep_rdy"}, W'(rep_ready), W'(r));
    chk({tag, "_cmt_rdy"}, W'(cmt_ready), W'(c));
  endtask

  logic [W-1:0] r1, r2, held;

  initial begin
    reset = 1; flush = 0; out_ready = 0;
    mis_valid = 0; rep_valid = 0; cmt_valid = 1;
    mis_bits = {13{32'h1234_5677}};
    rep_bits = {13{32'h5555_AAA9}};
    cmt_bits = {13{32'hDEAD_ABC3}};
    tick();
    rdy("rst", 0, 0, 0);
    tick();
    chk("rst_ov", W'(out_valid), '0);
    chk("rst_bits", out_bits, '0);
    chk("rst_src", W'(out_src), '0);
    chk("rst_starve", W'(starve_cnt), '0);
    reset = 0;

    // single commit source
    out_ready = 1;
    rdy("single", 0, 0, 1);
    tick();
    cmt_valid = 0;
    chk("single_ov", W'(out_valid), W'(1));
    chk("single_bits", out_bits, fl(cmt_bits, 2'b00));
    chk("single_src", W'(out_src), W'(2));
    tick();
    chk("drain_ov", W'(out_valid), '0);
    chk("drain_src", W'(out_src), W'(2));

    // fixed priority
    mis_valid = 1; rep_valid = 1; cmt_valid = 1;
    rdy("pri0", 1, 0, 0);
    tick();
    mis_valid = 0;
    chk("pri0_src", W'(out_src), W'(0));
    chk("pri0_bits", out_bits, fl(mis_bits, 2'b01));
    chk("pri0_starve", W'(starve_cnt), W'(1));
    rdy("pri1", 0, 1, 0);
    tick();
    rep_valid = 0;
    chk("pri1_src", W'(out_src), W'(1));
    chk("pri1_bits", out_bits, fl(rep_bits, 2'b10));
    chk("pri1_starve", W'(starve_cnt), W'(2));
    rdy("pri2", 0, 0, 1);
    tick();
    cmt_valid = 0;
    chk("pri2_src", W'(out_src), W'(2));
    chk("pri2_bits", out_bits, fl(cmt_bits, 2'b00));
    chk("pri2_starve", W'(starve_cnt), W'(0));
    tick();

    // starvation guard: 7 mis wins then a forced cmt win
    mis_valid = 1; cmt_valid = 1;
    for (int i = 0; i < 9; i++) begin
      rdy($sformatf("stv%0d", i), i != 7, 0, i == 7);
      tick();
      chk($sformatf("stv%0d_src", i), W'(out_src),
          W'(i == 7 ? 2 : 0));
      chk($sformatf("stv%0d_cnt", i), W'(starve_cnt),
          W'(i < 7 ? i + 1 : (i == 7 ? 0 : 1)));
    end
    mis_valid = 0; cmt_valid = 0;
    tick();
    chk("stv_end_ov", W'(out_valid), '0);

    // backpressure with rep pending
    r1 = {13{32'h0F0F_1111}};
    r2 = {13{32'h7777_2222}};
    rep_valid = 1; rep_bits = r1;
    tick();
    chk("bp_load", out_bits, fl(r1, 2'b10));
    rep_bits = r2; out_ready = 0;
    held = out_bits;
    for (int i = 0; i < 5; i++) begin
      rdy($sformatf("bp%0d", i), 0, 0, 0);
      tick();
      chk($sformatf("bp%0d_bits", i), out_bits, held);
      chk($sformatf("bp%0d_ov", i), W'(out_valid), W'(1));
      chk($sformatf("bp%0d_cnt", i), W'(starve_cnt), W'(1));
    end
    out_ready = 1;
    rdy("bp_rise", 0, 1, 0);
    tick();
    rep_valid = 0;
    chk("bp_new", out_bits, fl(r2, 2'b10));
    chk("bp_src", W'(out_src), W'(1));
    tick();

    // flush with out_valid=1 and starve_cnt=4
    mis_valid = 1; cmt_valid = 1;
    tick(); tick(); tick();
    chk("fl_pre_cnt", W'(starve_cnt), W'(4));
    chk("fl_pre_ov", W'(out_valid), W'(1));
    flush = 1;
    rdy("fl", 0, 0, 0);
    tick();
    flush = 0;
    chk("fl_ov", W'(out_valid), '0);
    chk("fl_cnt", W'(starve_cnt), '0);
    rdy("fl_after", 1, 0, 0);
    tick();
    chk("fl_after_ov", W'(out_valid), W'(1));
    chk("fl_after_src", W'(out_src), W'(0));
    mis_valid = 0; cmt_valid = 0;
    tick();

    // reset mid-stream with a held output
    rep_valid = 1;
    tick();
    out_ready = 0;
    reset = 1;
    rdy("mrst", 0, 0, 0);
    tick();
    reset = 0;
    chk("mrst_ov", W'(out_valid), '0);
    chk("mrst_bits", out_bits, '0);
    chk("mrst_src", W'(out_src), '0);
    chk("mrst_cnt", W'(starve_cnt), '0);
    rdy("mrst_after", 0, 1, 0);
    tick();
    rep_valid = 0;
    chk("mrst_after_ov", W'(out_valid), W'(1));
    chk("mrst_after_bits", out_bits, fl(r2, 2'b10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpd_update_arbiter.md
# bpd_update_arbiter

Shares the single branch-predictor update port among three producers: the mispredict-update path, the repair-walk path, and the commit-update queue (the 2-entry update FIFO on the commit side). Each cycle the block selects one source by fixed priority, with a starvation guard for commit traffic. It registers the winner into a 1-entry output stage with valid/ready flow control, and stamps the `is_mispredict_update`/`is_repair_update` flags according to the winning source. It sits between those producers and the predictor bank update inputs.

## Interface
Parameters:
- `UPD_W`, default 412: width of the packed update payload. Bit 0 is `is_mispredict_update` and bit 1 is `is_repair_update`; the remaining bits are opaque.
- `STARVE_LIMIT`, default 7: consecutive losing accept-cycles after which commit is forced to win. Legal range 1..255.

Ports:
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `flush`  in  1: drops the output stage and clears the starvation state.
- `mis_valid` in 1, `mis_ready` out 1, `mis_bits` in UPD_W: mispredict-update source (priority 0, highest).
- `rep_valid` in 1, `rep_ready` out 1, `rep_bits` in UPD_W: repair-update source (priority 1).
- `cmt_valid` in 1, `cmt_ready` out 1, `cmt_bits` in UPD_W: commit-queue source (priority 2).
- `out_valid`  out  1: update is present on the output.
- `out_ready`  in  1: predictor accepts the update.
- `out_bits`  out  UPD_W: registered update payload.
- `out_src`  out  2: source of the current output. 0 = mis, 1 = rep, 2 = cmt.
- `starve_cnt`  out  8: current commit starvation count (debug).

## Operation
- `can_load = ~out_valid | out_ready`. This is evaluated combinationally within the same cycle.
- Normal grant is fixed priority: mis > rep > cmt, considering only sources with valid high.
- Forced grant: when `starve_cnt == STARVE_LIMIT` and `cmt_valid` is high, cmt wins over both other sources.
- Ready outputs:
  - `X_ready = can_load & grant_X & ~flush`.
  - At most one ready is high per cycle.
  - A ready may be high only for a source whose valid is high.
- Load: when a grant fires (`X_valid & X_ready`), the output register takes `X_bits` with flag bits [1:0] overwritten as follows:
  - mis → 2'b01.
  - rep → 2'b10.
  - cmt → 2'b00.
  - The register also sets `out_src = X` and `out_valid = 1`.
- Drain: if `out_valid & out_ready` and no grant fires, `out_valid` goes to 0. `out_bits` and `out_src` hold their values.
- Starvation counter, evaluated only in cycles where `can_load & ~flush`:
  - If cmt is granted, the counter goes to 0.
  - Else if `cmt_valid` is high, the counter increments, saturating at `STARVE_LIMIT`.
  - Else the counter holds.
  - In all other cycles the counter holds.
- Flush:
  - Next cycle: `out_valid = 0` and `starve_cnt = 0`.
  - All readies are 0 in the flush cycle, so no source is consumed.
  - An output handshake coinciding with flush still counts as accepted by the predictor.
- Reset values: `out_valid` 0, `out_bits` 0, `out_src` 0, `starve_cnt` 0. All readies are 0 while reset is high.

## Timing
- Latency: an update granted in cycle N is visible on `out_*` in cycle N+1.
- Full throughput: one update per cycle while `out_ready` stays high.
- Backpressure: while `out_valid & ~out_ready`, all readies are 0 and `out_*` is stable.
- Sources must hold valid and bits until their handshake completes. A source losing arbitration is not consumed.
- Simultaneous load and drain in the same cycle: the new payload replaces the old one and `out_valid` stays 1.
- Reset or flush mid-stall: the held output is discarded and no source data is lost.

## Structure
- Shared package `bpd_upd_pkg` holds:
  - localparams `SRC_MIS = 2'd0`, `SRC_REP = 2'd1`, `SRC_CMT = 2'd2`.
  - `FLAG_MIS_BIT = 0`, `FLAG_REP_BIT = 1`.
  - `UPD_W_DEFAULT = 412`.
- One sub-module, `bpd_upd_prio_sel`: combinational 3-way priority select with a force-cmt input, outputting one-hot grants. The output register and starvation counter stay in the top module.
- Expected size is about 150–200 lines.

## Test plan
- Single source: `cmt_valid` held 1 with bits = 0x...ABC3 for one handshake, `out_ready` = 1.
  - Next cycle: `out_valid` = 1, `out_bits[1:0]` = 00 with upper bits equal to the input, `out_src` = 2.
- Priority: mis, rep and cmt all valid in the same cycle.
  - Only `mis_ready` = 1.
  - `out_src` sequence over three cycles is 0, 1, 2 if each source drops valid after its handshake.
  - Flags sequence is 01, 10, 00.
- Starvation: mis and cmt held valid continuously, `out_ready` = 1, `STARVE_LIMIT` = 7.
  - mis wins 7 cycles, cmt wins on the 8th, then `starve_cnt` returns to 0 and mis resumes.
- Backpressure: `out_ready` = 0 for 5 cycles with rep valid.
  - `rep_ready` = 0 throughout, `out_*` stable, `starve_cnt` unchanged.
  - The cycle `out_ready` rises, `rep_ready` = 1 and the new payload appears the next cycle.
- Flush: flush asserted while `out_valid` = 1 and `starve_cnt` = 4.
  - All readies are 0 that cycle.
  - Next cycle `out_valid` = 0 and `starve_cnt` = 0.
  - The pending source is still valid and is granted afterwards.
- Reset: `reset` asserted for 1 cycle mid-stream.
  - All outputs and readies are at their reset values the following cycle, and arbitration restarts cleanly.
